int8_mac_accumulator: RTL and testbench

- Upstream feeder of the int32→uint8 down-scaling/requantization stage.
- Consumes a stream of uint8 activation/weight pairs and subtracts their zero points.
- Multiplies and accumulates `len_i` products into a signed 32-bit accumulator.
- Presents the final int32 sum on a valid/ready output that connects directly to the down-scaler's data/valid inputs.

---
 rtl/int8_mac_accumulator.sv | 137 +++++++++++++
 tb/tb_int8_mac_accumulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int8_mac_accumulator.sv
// Zero-point-corrected uint8 multiply-accumulate into a signed accumulator,
// with a valid/ready result port feeding the requantization stage.
module int8_mac_accumulator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] z1_i,
  input  logic [DATA_WIDTH-1:0] z2_i,
  input  logic                  act_valid_i,
  input  logic [DATA_WIDTH-1:0] act_data_i,
  input  logic [DATA_WIDTH-1:0] wgt_data_i,
  output logic                  act_ready_o,
  output logic                  acc_valid_o,
  output logic [ACC_WIDTH-1:0]  acc_data_o,
  output logic                  acc_ovf_o,
  input  logic                  acc_ready_i,
  output logic                  busy_o
);

  localparam int unsigned PW = 2 * (DATA_WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  logic [1:0]                   r_state;
  logic [LEN_WIDTH-1:0]         r_len;
  logic [LEN_WIDTH-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0]        r_z1;
  logic [DATA_WIDTH-1:0]        r_z2;
  logic signed [PW-1:0]         r_prod;
  logic                         r_prod_v;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_ovf;
  logic [ACC_WIDTH-1:0]         r_acc_data;
  logic                         r_ovf_out;
  logic                         r_acc_valid;

  logic                         w_beat;
  logic signed [DATA_WIDTH:0]   w_da;
  logic signed [DATA_WIDTH:0]   w_dw;
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic                         w_ovf;

  always_comb begin
    w_beat     = act_valid_i && (r_state == S_ACCUM);
    w_da       = $signed({1'b0, act_data_i}) - $signed({1'b0, r_z1});
    w_dw       = $signed({1'b0, wgt_data_i}) - $signed({1'b0, r_z2});
    w_prod     = PW'(w_da) * PW'(w_dw);
    w_prod_ext = {{(ACC_WIDTH - PW){r_prod[PW-1]}}, r_prod};
    w_sum      = r_acc + w_prod_ext;
    w_ovf      = (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                 (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_z1        <= '0;
      r_z2        <= '0;
      r_prod      <= '0;
      r_prod_v    <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_acc_data  <= '0;
      r_ovf_out   <= 1'b0;
      r_acc_valid <= 1'b0;
    end else begin
      r_prod_v <= w_beat;
      if (w_beat) r_prod <= w_prod;
      if (r_prod_v) begin
        r_acc <= w_sum;
        if (w_ovf) r_ovf <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            if (len_i != '0) begin
              r_len   <= len_i;
              r_z1    <= z1_i;
              r_z2    <= z2_i;
              r_cnt   <= '0;
              r_state <= S_ACCUM;
            end else begin
              r_acc_data  <= '0;
              r_ovf_out   <= 1'b0;
              r_acc_valid <= 1'b1;
              r_state     <= S_OUTPUT;
            end
          end
        end
        S_ACCUM: begin
          if (w_beat) begin
            r_cnt <= r_cnt + LEN_WIDTH'(1);
            if (r_cnt == r_len - LEN_WIDTH'(1)) r_state <= S_DRAIN;
          end
        end
        // Held while the last product is still being added, so the result
        // register captures the fully accumulated value one edge later.
        S_DRAIN: begin
          if (!r_prod_v) begin
            r_acc_data  <= r_acc;
            r_ovf_out   <= r_ovf;
            r_acc_valid <= 1'b1;
            r_state     <= S_OUTPUT;
          end
        end
        default: begin
          if (acc_ready_i) begin
            r_acc_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign act_ready_o = (r_state == S_ACCUM);
  assign busy_o      = (r_state != S_IDLE);
  assign acc_valid_o = r_acc_valid;
  assign acc_data_o  = r_acc_data;
  assign acc_ovf_o   = r_ovf_out;

endmodule

// File: tb/tb_int8_mac_accumulator.sv
// Scoreboard bench for int8_mac_accumulator: random jobs against an
// arithmetic reference model, plus directed latency, stall and abort cases.
module tb_int8_mac_accumulator;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst, start, act_valid, act_ready, acc_valid, acc_ovf, acc_ready, busy;
  logic [LW-1:0] len;
  logic [DW-1:0] z1, z2, act, wgt;
  logic [AW-1:0] acc_data;

  always #5 clk = ~clk;

  int8_mac_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .z1_i(z1), .z2_i(z2),
    .act_valid_i(act_valid), .act_data_i(act), .wgt_data_i(wgt), .act_ready_o(act_ready),
    .acc_valid_o(acc_valid), .acc_data_o(acc_data), .acc_ovf_o(acc_ovf),
    .acc_ready_i(acc_ready), .busy_o(busy)
  );

  typedef struct { int data; bit ovf; bit len0; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0;
  int   g_act[], g_wgt[];
  int   rdy_mode = 0, hold_cnt = 0;

  task automatic chk(input string name, input longint actual, input longint expv);
    n_vec++;
    if (actual !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expv);
    end
  endtask

  // Reference: exact 64-bit running sum per product, wrapped to 32 bits.
  function automatic exp_t model(input int n, input int zz1, input int zz2);
    exp_t   e;
    int     acc = 0;
    longint t;
    e.ovf  = 1'b0;
    e.len0 = (n == 0);
    for (int i = 0; i < n; i++) begin
      t = longint'(acc) + longint'((g_act[i] - zz1) * (g_wgt[i] - zz2));
      if (t > MAXV || t < MINV) e.ovf = 1'b1;
      acc = int'(t);
    end
    e.data = acc;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: acc_ready = 1'b1;
      1: acc_ready = 1'($urandom_range(0, 1));
      default: begin
        if (acc_valid && hold_cnt < 5) begin
          acc_ready = 1'b0;
          hold_cnt++;
        end else acc_ready = (hold_cnt >= 5);
      end
    endcase
  end

  int nneg = 0, start_neg = 0, beat_neg = 0;
  bit prev_v = 0, prev_hs = 0, prev_o = 0;
  logic [AW-1:0] prev_d = '0;

  always @(negedge clk) begin
    nneg++;
    if (rst) begin
      prev_v  = 0;
      prev_hs = 0;
    end else begin
      if (prev_hs) begin
        chk("valid_drop", acc_valid, 0);
        chk("idle_after_hs", busy, 0);
      end else if (prev_v) begin
        chk("hold_valid", acc_valid, 1);
        chk("hold_data", acc_data, prev_d);
        chk("hold_ovf", acc_ovf, prev_o);
      end
      if (acc_valid && !prev_v) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got data %0d, required no result", $signed(acc_data));
        end else
          chk("latency", nneg, sb[0].len0 ? start_neg + 1 : beat_neg + 3);
      end
      if (acc_valid && acc_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("acc_data", $signed(acc_data), mon_e.data);
        chk("acc_ovf", acc_ovf, mon_e.ovf);
      end
      if (start && !busy) start_neg = nneg;
      if (act_valid && act_ready) beat_neg = nneg;
      prev_v  = acc_valid;
      prev_hs = acc_valid && acc_ready;
      prev_d  = acc_data;
      prev_o  = acc_ovf;
    end
  end

  // vmode: 0 always valid, 1 random gaps, 2 repeating 1,0,0,1,0,1.
  task automatic run_job(input int n, input int zz1, input int zz2, input int vmode,
                         input bit inject, input int rst_after);
    exp_t e;
    int   k = 0, t = 0, step = 0;
    e = model(n, zz1, zz2);
    if (rst_after < 0) sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; len = LW'(n); z1 = DW'(zz1); z2 = DW'(zz2);
    @(posedge clk); #1;
    start = 1'b0; len = LW'($urandom); z1 = DW'($urandom); z2 = DW'($urandom);
    while (k < n && t < 4 * n + 50) begin
      if (rst_after == k) begin
        rst = 1'b1; act_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_act_ready", act_ready, 0);
        chk("abort_acc_valid", acc_valid, 0);
        chk("abort_acc_data", acc_data, 0);
        chk("abort_acc_ovf", acc_ovf, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        return;
      end
      case (vmode)
        0: act_valid = 1'b1;
        1: act_valid = ($urandom_range(0, 2) != 0);
        default: act_valid = (step % 6 == 0) || (step % 6 == 3) || (step % 6 == 5);
      endcase
      step++;
      act   = act_valid ? DW'(g_act[k]) : DW'($urandom);
      wgt   = act_valid ? DW'(g_wgt[k]) : DW'($urandom);
      start = inject && (k == 1);
      @(negedge clk);
      if (act_valid && act_ready) k++;
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    if (k < n) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", k, n);
    end
    act_valid = 1'b1; act = DW'($urandom); wgt = DW'($urandom);
    @(negedge clk);
    chk("ready_low_after_last", act_ready, 0);
    @(posedge clk); #1;
    act_valid = 1'b0;
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL result_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    g_act = new[n];
    g_wgt = new[n];
    for (int i = 0; i < n; i++) begin
      g_act[i] = $urandom_range(0, 255);
      g_wgt[i] = $urandom_range(0, 255);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; z1 = '0; z2 = '0;
    act_valid = 1'b0; act = '0; wgt = '0; acc_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_act_ready", act_ready, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_data", acc_data, 0);
    chk("rst_acc_ovf", acc_ovf, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    g_act = new[4]; g_wgt = new[4];
    for (int i = 0; i < 4; i++) begin g_act[i] = 10 * (i + 1); g_wgt[i] = 3; end
    run_job(4, 0, 0, 0, 0, -1);

    g_act = new[1]; g_wgt = new[1];
    g_act[0] = 5; g_wgt[0] = 7;
    run_job(1, 10, 2, 0, 0, -1);

    g_act = new[3]; g_wgt = new[3];
    for (int i = 0; i < 3; i++) begin g_act[i] = 2; g_wgt[i] = 2; end
    run_job(3, 0, 0, 2, 0, -1);

    fill_random(6);
    rdy_mode = 2; hold_cnt = 0;
    run_job(6, $urandom_range(0, 255), $urandom_range(0, 255), 1, 0, -1);
    rdy_mode = 0;

    g_act = new[33026]; g_wgt = new[33026];
    for (int i = 0; i < 33026; i++) begin g_act[i] = 255; g_wgt[i] = 255; end
    run_job(33026, 0, 0, 0, 0, -1);

    fill_random(1);
    run_job(1, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, -1);

    run_job(0, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, -1);

    fill_random(8);
    run_job(8, $urandom_range(0, 255), $urandom_range(0, 255), 1, 1, -1);

    fill_random(6);
    run_job(6, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 2);

    fill_random(2);
    run_job(2, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, -1);

    rdy_mode = 1;
    for (int j = 0; j < 20; j++) begin
      int n;
      n = $urandom_range(1, 20);
      fill_random(n);
      run_job(n, $urandom_range(0, 255), $urandom_range(0, 255), 1, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
